// File: rtl/gen_fifo_defines_pkg.sv
// Shared definitions for the generator datapath: adder-tree result modes and
// helpers that size the reduction tree from the operand count.
package gen_fifo_defines_pkg;

  // bit 1 selects accumulation, bit 0 selects saturation
  typedef enum logic [1:0] {
    ADD_WRAP     = 2'b00,
    ADD_SAT      = 2'b01,
    ADD_ACC_WRAP = 2'b10,
    ADD_ACC_SAT  = 2'b11
  } adder_mode_e;

  localparam int ADDER_MIN_IN = 2;
  localparam int ADDER_MAX_IN = 16;

  // Number of pairwise reduction levels needed for n operands.
  function automatic int tree_depth(input int n);
    return $clog2(n);
  endfunction

  // Operand count after zero-padding up to the next power of two.
  function automatic int tree_leaves(input int n);
    return 1 << tree_depth(n);
  endfunction

  // Width of one level's operands, growing one bit per level.
  function automatic int level_width(input int width, input int level);
    return width + level;
  endfunction

  function automatic bit is_acc(input adder_mode_e mode);
    return mode inside {ADD_ACC_WRAP, ADD_ACC_SAT};
  endfunction

  function automatic bit is_sat(input adder_mode_e mode);
    return mode inside {ADD_SAT, ADD_ACC_SAT};
  endfunction

endpackage

// File: rtl/funct_generator_adder_level.sv
// One reduction level of the generator adder tree: adds operands pairwise,
// widening by one bit, with an optional enh-qualified pipeline register.
module funct_generator_adder_level #(
  parameter int WIDTH  = 8,
  parameter int NUM_IN = 4,
  parameter int PIPE   = 1
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic                                   clrh,
  input  logic                                   enh,
  input  logic [NUM_IN*WIDTH-1:0]                operands,
  output logic [((NUM_IN+1)/2)*(WIDTH+1)-1:0]    sums
);

  localparam int NUM_OUT = (NUM_IN + 1) / 2;
  localparam int OUT_W   = WIDTH + 1;

  logic [NUM_OUT*OUT_W-1:0] sum_comb;
  logic [NUM_OUT*OUT_W-1:0] sum_q;

  for (genvar k = 0; k < NUM_OUT; k++) begin : g_pair
    logic [WIDTH-1:0] lhs;
    logic [WIDTH-1:0] rhs;

    assign lhs = operands[2*k*WIDTH +: WIDTH];

    // an odd trailing operand is paired with zero
    if (2*k + 1 < NUM_IN) begin : g_rhs
      assign rhs = operands[(2*k+1)*WIDTH +: WIDTH];
    end else begin : g_pad
      assign rhs = '0;
    end

    assign sum_comb[k*OUT_W +: OUT_W] = {1'b0, lhs} + {1'b0, rhs};
  end

  // NOTE: state is written with <= so every level samples the previous
  // level's old value on the same edge, which is what makes this a pipeline.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sum_q <= '0;
    end else if (clrh) begin
      sum_q <= '0;
    end else if (enh) begin
      sum_q <= sum_comb;
    end
  end

  // With PIPE=0 the register has no load and disappears in synthesis.
  assign sums = (PIPE != 0) ? sum_q : sum_comb;

endmodule

// File: rtl/funct_generator_adder_tree.sv
// Registered NUM_IN-operand sum for the generator datapath: pairwise adder
// tree, mode/valid pipelines travelling with the data, and a wrap/saturate/
// accumulate output stage feeding the FIFO write side.
module funct_generator_adder_tree
  import gen_fifo_defines_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int NUM_IN = 4,
  parameter int PIPE   = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clrh,
  input  logic                     enh,
  input  logic [1:0]               mode_i,
  input  logic [NUM_IN*WIDTH-1:0]  data_i,
  output logic [WIDTH-1:0]         data_o,
  output logic                     valid_o,
  output logic                     ovf_o
);

  localparam int DEPTH  = tree_depth(NUM_IN);
  localparam int LEAVES = tree_leaves(NUM_IN);
  localparam int SUM_W  = WIDTH + DEPTH;
  localparam int TOT_W  = SUM_W + 1;

  typedef logic [LEAVES*WIDTH-1:0] padded_t;
  typedef logic [TOT_W-1:0]        total_t;

  padded_t          padded;
  logic [SUM_W-1:0] tree_sum;

  // Missing operands up to the next power of two read as zero.
  assign padded = padded_t'(data_i);

  // ---------------------------------------------------------------------------
  // Adder tree
  // ---------------------------------------------------------------------------
  for (genvar l = 0; l < DEPTH; l++) begin : g_lvl
    localparam int LVL_W  = level_width(WIDTH, l);
    localparam int LVL_IN = LEAVES >> l;

    logic [LVL_IN*LVL_W-1:0]               operands;
    logic [((LVL_IN+1)/2)*(LVL_W+1)-1:0]   sums;

    if (l == 0) begin : g_first
      assign operands = padded;
    end else begin : g_next
      assign operands = g_lvl[l-1].sums;
    end

    funct_generator_adder_level #(
      .WIDTH  (LVL_W),
      .NUM_IN (LVL_IN),
      .PIPE   (PIPE)
    ) u_level (
      .clk      (clk),
      .rst      (rst),
      .clrh     (clrh),
      .enh      (enh),
      .operands (operands),
      .sums     (sums)
    );
  end

  assign tree_sum = g_lvl[DEPTH-1].sums;

  // ---------------------------------------------------------------------------
  // Mode and valid pipelines, one entry per tree level
  // ---------------------------------------------------------------------------
  adder_mode_e      mode_q [DEPTH];
  logic [DEPTH-1:0] vld_q;

  // NOTE: the small mode/valid arrays are reset alongside the datapath;
  // an unreset valid bit would emit a phantom result after power-up.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vld_q <= '0;
      for (int i = 0; i < DEPTH; i++) mode_q[i] <= ADD_WRAP;
    end else if (clrh) begin
      vld_q <= '0;
      for (int i = 0; i < DEPTH; i++) mode_q[i] <= ADD_WRAP;
    end else if (enh) begin
      vld_q[0]  <= 1'b1;
      mode_q[0] <= adder_mode_e'(mode_i);
      for (int i = 1; i < DEPTH; i++) begin
        vld_q[i]  <= vld_q[i-1];
        mode_q[i] <= mode_q[i-1];
      end
    end
  end

  adder_mode_e mode_last;
  logic        vld_last;

  // Without pipelining the operands reach the output stage in the capture cycle.
  assign mode_last = (PIPE != 0) ? mode_q[DEPTH-1] : adder_mode_e'(mode_i);
  assign vld_last  = (PIPE != 0) ? vld_q[DEPTH-1]  : 1'b1;

  // ---------------------------------------------------------------------------
  // Output stage
  // ---------------------------------------------------------------------------
  total_t           base;
  total_t           total;
  logic             over;
  logic [WIDTH-1:0] data_next;

  // NOTE: every signal gets a value on every path here, so no latch is inferred.
  always_comb begin
    base      = is_acc(mode_last) ? total_t'(data_o) : '0;
    total     = base + total_t'(tree_sum);
    over      = |total[TOT_W-1:WIDTH];
    data_next = (is_sat(mode_last) && over) ? '1 : total[WIDTH-1:0];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      data_o  <= '0;
      valid_o <= 1'b0;
      ovf_o   <= 1'b0;
    end else if (clrh) begin
      data_o  <= '0;
      valid_o <= 1'b0;
      ovf_o   <= 1'b0;
    end else if (enh) begin
      valid_o <= vld_last;
      // bubbles advance through the output stage without touching the result
      if (vld_last) begin
        data_o <= data_next;
        ovf_o  <= over;
      end
    end else begin
      valid_o <= 1'b0;
    end
  end

endmodule

// File: tb/tb_funct_generator_adder_tree.sv
// Self-checking bench for funct_generator_adder_tree: a pipelined 4-operand
// instance checked through a result scoreboard, plus a PIPE=0 3-operand instance.
module tb_funct_generator_adder_tree;

  localparam logic [1:0] M_WRAP = 2'b00;
  localparam logic [1:0] M_SAT  = 2'b01;
  localparam logic [1:0] M_AW   = 2'b10;
  localparam logic [1:0] M_AS   = 2'b11;
  localparam int         LAT    = 3;

  logic        clk;
  logic        rst;
  logic        clrh;
  logic        enh;
  logic [1:0]  mode_i;
  logic [31:0] data_i;
  logic [7:0]  data_o;
  logic        valid_o;
  logic        ovf_o;

  logic        clrh2;
  logic        enh2;
  logic [1:0]  mode2;
  logic [23:0] data2;
  logic [7:0]  out2;
  logic        valid2;
  logic        ovf2;

  int compared   = 0;
  int mismatched = 0;
  int model_acc  = 0;
  logic [8:0] exp_q [$];

  funct_generator_adder_tree #(.WIDTH(8), .NUM_IN(4), .PIPE(1)) dut (
    .clk     (clk),
    .rst     (rst),
    .clrh    (clrh),
    .enh     (enh),
    .mode_i  (mode_i),
    .data_i  (data_i),
    .data_o  (data_o),
    .valid_o (valid_o),
    .ovf_o   (ovf_o)
  );

  funct_generator_adder_tree #(.WIDTH(8), .NUM_IN(3), .PIPE(0)) dut_comb (
    .clk     (clk),
    .rst     (rst),
    .clrh    (clrh2),
    .enh     (enh2),
    .mode_i  (mode2),
    .data_i  (data2),
    .data_o  (out2),
    .valid_o (valid2),
    .ovf_o   (ovf2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Scoreboard: every result the pipelined DUT emits must match the oldest expectation.
  always @(negedge clk) begin
    if (rst === 1'b1 && valid_o === 1'b1) begin
      compared++;
      if (exp_q.size() == 0) begin
        mismatched++;
        $display("FAIL unexpected_result: got data_o=%0d ovf_o=%0b, required no result", data_o, ovf_o);
      end else begin
        logic [8:0] e;
        e = exp_q.pop_front();
        if ({ovf_o, data_o} !== e) begin
          mismatched++;
          $display("FAIL scoreboard: got data_o=%0d ovf_o=%0b, required data_o=%0d ovf_o=%0b",
                   data_o, ovf_o, e[7:0], e[8]);
        end
      end
    end
  end

  task automatic expect_bit(input string name, input logic got, input logic req);
    compared++;
    if (got !== req) begin
      mismatched++;
      $display("FAIL %s: got %0b, required %0b", name, got, req);
    end
  endtask

  task automatic expect_byte(input string name, input logic [7:0] got, input logic [7:0] req);
    compared++;
    if (got !== req) begin
      mismatched++;
      $display("FAIL %s: got %0d, required %0d", name, got, req);
    end
  endtask

  // Reference model: integer arithmetic on the operand sum, in capture order.
  task automatic push_exp(input int s, input logic [1:0] m);
    int t;
    int d;
    bit o;
    t = m[1] ? model_acc + s : s;
    o = (t > 255);
    d = (m[0] && o) ? 255 : (t % 256);
    model_acc = d;
    exp_q.push_back({o, 8'(d)});
  endtask

  task automatic step(input logic [31:0] d, input logic [1:0] m);
    data_i = d;
    mode_i = m;
    enh    = 1'b1;
    clrh   = 1'b0;
    push_exp(int'(d[7:0]) + int'(d[15:8]) + int'(d[23:16]) + int'(d[31:24]), m);
    @(posedge clk);
    @(negedge clk);
  endtask

  // Pushes enough trailing tokens for everything real to reach the output.
  task automatic settle();
    for (int i = 0; i < LAT - 1; i++) step(32'h0, M_WRAP);
  endtask

  task automatic do_clear();
    clrh   = 1'b1;
    enh    = 1'b1;
    data_i = $urandom;
    mode_i = 2'($urandom_range(0, 3));
    @(posedge clk);
    @(negedge clk);
    expect_byte("clear_data", data_o, 8'd0);
    expect_bit("clear_valid", valid_o, 1'b0);
    expect_bit("clear_ovf", ovf_o, 1'b0);
    clrh = 1'b0;
    enh  = 1'b0;
    exp_q.delete();
    model_acc = 0;
  endtask

  task automatic test_reset();
    rst = 1'b1; clrh = 1'b0; enh = 1'b0; mode_i = M_WRAP; data_i = '0;
    clrh2 = 1'b0; enh2 = 1'b0; mode2 = M_WRAP; data2 = '0;
    #1 rst = 1'b0;
    #1;
    expect_byte("reset_data", data_o, 8'd0);
    expect_bit("reset_valid", valid_o, 1'b0);
    expect_bit("reset_ovf", ovf_o, 1'b0);
    expect_byte("reset_data_comb", out2, 8'd0);
    expect_bit("reset_valid_comb", valid2, 1'b0);
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_wrap_basic();
    step({8'd40, 8'd30, 8'd20, 8'd10}, M_WRAP);
    expect_bit("wrap_latency_1", valid_o, 1'b0);
    step({8'd40, 8'd30, 8'd20, 8'd10}, M_WRAP);
    expect_bit("wrap_latency_2", valid_o, 1'b0);
    step({8'd40, 8'd30, 8'd20, 8'd10}, M_WRAP);
    expect_bit("wrap_latency_3", valid_o, 1'b1);
    expect_byte("wrap_data", data_o, 8'd100);
    expect_bit("wrap_ovf", ovf_o, 1'b0);
    settle();
    do_clear();
  endtask

  task automatic test_overflow();
    step({4{8'd100}}, M_WRAP);
    step({4{8'd100}}, M_SAT);
    settle();
    do_clear();
  endtask

  task automatic test_accumulate();
    logic [1:0] modes [2];
    modes[0] = M_AW;
    modes[1] = M_AS;
    foreach (modes[j]) begin
      for (int i = 0; i < 5; i++) step({4{8'd1}}, modes[j]);
      step({4{8'd60}}, modes[j]);
      settle();
      expect_byte("acc_final", data_o, (j == 0) ? 8'd4 : 8'd255);
      do_clear();
    end
  endtask

  task automatic test_stall();
    step({8'd1, 8'd2, 8'd3, 8'd4}, M_WRAP);
    step({4{8'd50}}, M_WRAP);
    step({8'd200, 8'd100, 8'd0, 8'd0}, M_WRAP);
    enh    = 1'b0;
    data_i = 32'hFFFF_FFFF;
    mode_i = M_SAT;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      @(negedge clk);
      expect_byte("stall_data", data_o, 8'd10);
      expect_bit("stall_ovf", ovf_o, 1'b0);
      expect_bit("stall_valid", valid_o, 1'b0);
    end
    settle();
    do_clear();
  endtask

  task automatic test_clear();
    step({4{8'd100}}, M_WRAP);
    step({4{8'd77}}, M_WRAP);
    step({4{8'd99}}, M_SAT);
    do_clear();
    step({8'd1, 8'd2, 8'd3, 8'd4}, M_WRAP);
    expect_bit("no_stale_1", valid_o, 1'b0);
    step({8'd1, 8'd2, 8'd3, 8'd4}, M_WRAP);
    expect_bit("no_stale_2", valid_o, 1'b0);
    settle();
    do_clear();
  endtask

  task automatic test_mode_align();
    step({4{8'd100}}, M_WRAP);
    step({4{8'd100}}, M_SAT);
    step({4{8'd100}}, M_WRAP);
    settle();
    do_clear();
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 24; i++) step($urandom, 2'($urandom_range(0, 3)));
    settle();
    do_clear();
  endtask

  task automatic test_async_reset();
    for (int i = 0; i < 3; i++) step({4{8'd100}}, M_WRAP);
    expect_byte("pre_reset_data", data_o, 8'd144);
    #2 rst = 1'b0;
    #1;
    expect_byte("async_reset_data", data_o, 8'd0);
    expect_bit("async_reset_valid", valid_o, 1'b0);
    expect_bit("async_reset_ovf", ovf_o, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    exp_q.delete();
    model_acc = 0;
    step({8'd5, 8'd5, 8'd5, 8'd5}, M_WRAP);
    expect_bit("post_reset_1", valid_o, 1'b0);
    step({8'd5, 8'd5, 8'd5, 8'd5}, M_WRAP);
    expect_bit("post_reset_2", valid_o, 1'b0);
    settle();
    do_clear();
  endtask

  task automatic test_pipe0();
    data2 = {8'd7, 8'd5, 8'd3};
    mode2 = M_WRAP;
    enh2  = 1'b1;
    @(posedge clk);
    @(negedge clk);
    expect_byte("comb_data", out2, 8'd15);
    expect_bit("comb_valid", valid2, 1'b1);
    expect_bit("comb_ovf", ovf2, 1'b0);
    enh2  = 1'b0;
    data2 = 24'hFFFFFF;
    for (int i = 0; i < 2; i++) begin
      @(posedge clk);
      @(negedge clk);
      expect_byte("comb_hold_data", out2, 8'd15);
      expect_bit("comb_hold_valid", valid2, 1'b0);
    end
    enh2 = 1'b1;
    mode2 = M_SAT;
    @(posedge clk);
    @(negedge clk);
    expect_byte("comb_sat_data", out2, 8'd255);
    expect_bit("comb_sat_ovf", ovf2, 1'b1);
    mode2 = M_WRAP;
    @(posedge clk);
    @(negedge clk);
    expect_byte("comb_wrap_data", out2, 8'd253);
    expect_bit("comb_wrap_ovf", ovf2, 1'b1);
    enh2 = 1'b0;
  endtask

  initial begin
    test_reset();
    test_wrap_basic();
    test_overflow();
    test_accumulate();
    test_stall();
    test_clear();
    test_mode_align();
    test_back_to_back();
    test_async_reset();
    test_pipe0();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
